mmio_io_bridge: RTL and testbench
=================================

Name: mmio_io_bridge

Overview:
- Memory-mapped I/O peripheral that sits directly downstream of the single-cycle MIPS datapath.
- Consumes the same address (ALU result), write data (rs2 read data), MemWrite and MemRead signals that feed data RAM.
- Provides:
  - a registered 32-bit output port (drives processor PortOut);
  - a synchronized 8-bit input port with change detection (from PortIn);
  - an 8N1 UART transmitter.
- Top level muxes o_read_data into the MemtoReg path whenever o_sel=1.

Parameters:
- IO_BASE, 32'h0000_0100, byte base address of the 16-byte register window; IO_BASE[3:0] must be 0.
- CLKS_PER_BIT, 434, clk cycles per UART bit; legal values ≥ 2.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- i_address  in  32  byte address from ALU result
- i_write_data  in  32  store data
- i_mem_write  in  1  store strobe, one cycle per sw
- i_mem_read  in  1  load strobe
- o_sel  out  1  combinational: i_address[31:4]==IO_BASE[31:4]
- o_read_data  out  32  combinational load data
- i_port_in  in  8  asynchronous external input
- o_port_out  out  32  output port register
- o_uart_tx  out  1  UART serial line, idle high

Behaviour:
Reset:
- Asynchronous, active-high reset; all state clears immediately, independent of clk.
- Reset values: o_port_out=0, o_uart_tx=1, FSM=IDLE, busy=0, sync/prev regs=0, chg flag=0.
- Reset mid-frame aborts the frame; the line returns high at once.

Register map (offset = i_address[3:0]; i_address[1:0] ignored):
- 0x0 PORT_OUT: R/W. Store updates o_port_out at the next rising edge.
- 0x4 PORT_IN: RO. Returns {24'b0, in_sync}.
- 0x8 UART_TX: WO; reads return 0. A store of byte [7:0] starts a frame if not busy; see Optional Feature for stores while busy.
- 0xC STATUS: bit0 busy, bit1 chg, bit2 hold_full (0 when the macro is absent), other bits 0. A store with bit1=1 clears chg (write-1-to-clear); other bits are read-only.

Bus rules:
- Store takes effect only when o_sel & i_mem_write at a rising clk edge.
- o_read_data = register value when o_sel & i_mem_read, else 32'h0. It is combinational (zero latency) to suit the single-cycle load.
- Accesses with o_sel=0 have no effect.

Input path:
- Two-flop synchronizer produces in_sync, so latency from pin to readable value is 2 edges.
- prev register holds in_sync delayed one cycle.
- chg is set on any cycle where in_sync != prev.
- If set and W1C clear occur in the same cycle, set wins.

UART TX FSM:
- States: IDLE, START, DATA, STOP.
- IDLE: tx=1, busy=0. A UART_TX store loads the shift register, zeroes the baud counter and bit index, and moves to START. busy=1 from the next edge.
- START: tx=0 for CLKS_PER_BIT cycles, then go to DATA.
- DATA: shifts out bits LSB first, each for CLKS_PER_BIT cycles. After bit index 7, go to STOP.
- STOP: tx=1 for CLKS_PER_BIT cycles, then go to IDLE (or START if the hold register is full).
- Baud counter counts 0..CLKS_PER_BIT-1, with width $clog2(CLKS_PER_BIT).
- Frame length is exactly 10*CLKS_PER_BIT cycles. tx goes low on the edge that latches the store.
- Without the macro, a UART_TX store while busy=1 is silently dropped.

Optional Feature:
- Macro: MMIO_TX_HOLD_EN.
- Defined:
  - Adds a one-byte holding register and STATUS bit2 hold_full.
  - A store while busy with hold_full=0 captures the byte and sets hold_full.
  - At the end of STOP, if hold_full: load the held byte, clear hold_full, and go directly to START, giving back-to-back frames with no idle gap.
  - A store while hold_full=1 is dropped.
- Undefined: no holding register, and bit2 reads 0.

Test Plan:
1. Reset asserted mid-operation, async and between edges → o_port_out=0, o_uart_tx=1, STATUS=0 before the next clk edge.
2. sw 0xDEADBEEF to 0x100, then lw 0x100 → o_port_out=0xDEADBEEF one edge after the store; o_read_data=0xDEADBEEF. lw 0x108 → 0; lw 0x0FC → o_sel=0 and o_read_data=0.
3. i_port_in 0x00→0xA5 → PORT_IN reads 0xA5 after 2 edges and STATUS bit1=1. sw 0x2 to 0x10C → bit1=0. Toggle the input in the clear cycle → bit1 stays 1.
4. CLKS_PER_BIT=4, sw 0x55 to 0x108 → tx sequence over 40 cycles: 0,1,0,1,0,1,0,1,0,1, each held 4 cycles. busy=1 throughout, then 0.
5. While busy, sw 0x0F to 0x108 → without macro: dropped, only one frame sent. With MMIO_TX_HOLD_EN: hold_full=1, and a second frame (0,1,1,1,1,0,0,0,0,1) starts immediately after the first stop bit.
6. sw to 0x104 and 0x108 read back → PORT_IN unaffected; a read of UART_TX returns 0.

Source files
------------

// File: rtl/mmio_io_bridge.sv
// MMIO peripheral behind the single-cycle datapath: output port, synchronized input port, 8N1 UART TX.
// Optional macro MMIO_TX_HOLD_EN adds a one-byte TX holding register for back-to-back frames.
module mmio_io_bridge #(
    parameter logic [31:0] IO_BASE      = 32'h0000_0100,
    parameter int          CLKS_PER_BIT = 434
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] i_address,
    input  logic [31:0] i_write_data,
    input  logic        i_mem_write,
    input  logic        i_mem_read,
    output logic        o_sel,
    output logic [31:0] o_read_data,
    input  logic [7:0]  i_port_in,
    output logic [31:0] o_port_out,
    output logic        o_uart_tx
);

    // state | meaning
    // IDLE  | line high, ready for a new byte
    // START | start bit (low)
    // DATA  | eight data bits, LSB first
    // STOP  | stop bit (high), may chain into START
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] DATA  = 2'd2;
    localparam logic [1:0] STOP  = 2'd3;

    localparam int            BW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

    logic [31:0]   port_out_q;
    logic [7:0]    sync1_q, in_sync_q, prev_q;
    logic          chg_q, chg_d;
    logic [1:0]    state_q, state_d;
    logic [BW-1:0] baud_q, baud_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          tx_q, tx_d;

    logic       hold_full;
    logic       next_ready;
    logic [7:0] next_byte;

    logic [1:0] off;
    logic       wr, wr_port, wr_tx, wr_stat;
    logic       busy, baud_done, stop_end;
    logic       unused_addr_bits;

    assign o_sel            = (i_address[31:4] == IO_BASE[31:4]);
    assign off              = i_address[3:2];
    assign unused_addr_bits = ^i_address[1:0];
    assign wr               = o_sel & i_mem_write;
    assign wr_port          = wr & (off == 2'd0);
    assign wr_tx            = wr & (off == 2'd2);
    assign wr_stat          = wr & (off == 2'd3);
    assign busy             = (state_q != IDLE);
    assign baud_done        = (baud_q == BAUD_LAST);
    assign stop_end         = (state_q == STOP) & baud_done;

`ifdef MMIO_TX_HOLD_EN
    logic [7:0] hold_q, hold_d;
    logic       hold_full_q, hold_full_d;

    // A store landing on the final stop cycle bypasses the holder and chains directly.
    assign next_ready = hold_full_q | wr_tx;
    assign next_byte  = hold_full_q ? hold_q : i_write_data[7:0];
    assign hold_full  = hold_full_q;

    always_comb begin
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        if (stop_end) begin
            hold_full_d = 1'b0;
        end else if (wr_tx & busy & ~hold_full_q) begin
            hold_d      = i_write_data[7:0];
            hold_full_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_q      <= 8'h00;
            hold_full_q <= 1'b0;
        end else begin
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
        end
    end
`else
    assign next_ready = 1'b0;
    assign next_byte  = 8'h00;
    assign hold_full  = 1'b0;
`endif

    // Set beats a simultaneous write-1-to-clear so no edge is ever lost.
    assign chg_d = (in_sync_q != prev_q) | (chg_q & ~(wr_stat & i_write_data[1]));

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        case (state_q)
            IDLE: begin
                if (wr_tx) begin
                    shift_d = i_write_data[7:0];
                    baud_d  = '0;
                    bit_d   = 3'd0;
                    state_d = START;
                end
            end
            START: begin
                if (baud_done) begin
                    baud_d  = '0;
                    state_d = DATA;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            DATA: begin
                if (baud_done) begin
                    baud_d  = '0;
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            STOP: begin
                if (baud_done) begin
                    baud_d = '0;
                    if (next_ready) begin
                        shift_d = next_byte;
                        bit_d   = 3'd0;
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            port_out_q <= 32'h0;
            sync1_q    <= 8'h00;
            in_sync_q  <= 8'h00;
            prev_q     <= 8'h00;
            chg_q      <= 1'b0;
            state_q    <= IDLE;
            baud_q     <= '0;
            bit_q      <= 3'd0;
            shift_q    <= 8'h00;
            tx_q       <= 1'b1;
        end else begin
            if (wr_port) begin
                port_out_q <= i_write_data;
            end
            sync1_q   <= i_port_in;
            in_sync_q <= sync1_q;
            prev_q    <= in_sync_q;
            chg_q     <= chg_d;
            state_q   <= state_d;
            baud_q    <= baud_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
        end
    end

    always_comb begin
        o_read_data = 32'h0;
        if (o_sel & i_mem_read) begin
            case (off)
                2'd0:    o_read_data = port_out_q;
                2'd1:    o_read_data = {24'h0, in_sync_q};
                2'd2:    o_read_data = 32'h0;
                default: o_read_data = {29'h0, hold_full, chg_q, busy};
            endcase
        end
    end

    assign o_port_out = port_out_q;
    assign o_uart_tx  = tx_q;

endmodule

// File: tb/tb_mmio_io_bridge.sv
// Bench for mmio_io_bridge: cycle model of the register map and UART frames, plus directed literal checks.
// Build with MMIO_TX_HOLD_EN defined to exercise the holding register.
module tb_mmio_io_bridge;

    localparam int          CPB   = 4;
    localparam int          FRAME = 10 * CPB;
    localparam logic [31:0] BASE  = 32'h0000_0100;
`ifdef MMIO_TX_HOLD_EN
    localparam bit HOLD = 1'b1;
`else
    localparam bit HOLD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] i_address = BASE + 32'hC;
    logic [31:0] i_write_data = 32'h0;
    logic        i_mem_write = 1'b0;
    logic        i_mem_read = 1'b1;
    logic [7:0]  i_port_in = 8'h00;
    logic        o_sel;
    logic [31:0] o_read_data;
    logic [31:0] o_port_out;
    logic        o_uart_tx;

    int n_total = 0;
    int n_pass  = 0;

    mmio_io_bridge #(.IO_BASE(BASE), .CLKS_PER_BIT(CPB)) dut (
        .clk         (clk),
        .reset       (reset),
        .i_address   (i_address),
        .i_write_data(i_write_data),
        .i_mem_write (i_mem_write),
        .i_mem_read  (i_mem_read),
        .o_sel       (o_sel),
        .o_read_data (o_read_data),
        .i_port_in   (i_port_in),
        .o_port_out  (o_port_out),
        .o_uart_tx   (o_uart_tx)
    );

    always #5 clk = ~clk;

    // Model: pin samples as a delay line, UART as "cycles left in current frame" plus a pending byte.
    typedef struct packed {
        logic [31:0] port_out;
        logic [7:0]  ph0, ph1, ph2;
        logic        chg;
        logic [15:0] rem;
        logic [7:0]  cur;
        logic [7:0]  pend;
        logic        pend_v;
    } model_t;

    model_t m;

    function automatic model_t model_next(model_t c, logic [31:0] a, logic [31:0] d,
                                          logic we, logic [7:0] pin);
        model_t n;
        logic   hit;
        logic   was_busy;
        n        = c;
        hit      = (a[31:4] == BASE[31:4]) && we;
        was_busy = (c.rem != 16'd0);
        if (hit && a[3:2] == 2'd0) n.port_out = d;
        if (c.ph1 != c.ph2) n.chg = 1'b1;
        else if (hit && a[3:2] == 2'd3 && d[1]) n.chg = 1'b0;
        n.ph2 = c.ph1;
        n.ph1 = c.ph0;
        n.ph0 = pin;
        if (was_busy) n.rem = c.rem - 16'd1;
        if (hit && a[3:2] == 2'd2) begin
            if (!was_busy) begin
                n.rem = 16'(FRAME);
                n.cur = d[7:0];
            end else if (HOLD && !c.pend_v) begin
                n.pend   = d[7:0];
                n.pend_v = 1'b1;
            end
        end
        if (was_busy && n.rem == 16'd0 && n.pend_v) begin
            n.rem    = 16'(FRAME);
            n.cur    = n.pend;
            n.pend_v = 1'b0;
        end
        return n;
    endfunction

    function automatic logic exp_tx(model_t c);
        int idx;
        if (c.rem == 16'd0) return 1'b1;
        idx = (FRAME - int'(c.rem)) / CPB;
        if (idx == 0) return 1'b0;
        if (idx == 9) return 1'b1;
        return c.cur[idx-1];
    endfunction

    function automatic logic [31:0] exp_rd(model_t c, logic [31:0] a, logic rd);
        if (!rd || a[31:4] != BASE[31:4]) return 32'h0;
        case (a[3:2])
            2'd0:    return c.port_out;
            2'd1:    return {24'h0, c.ph1};
            2'd2:    return 32'h0;
            default: return {29'h0, c.pend_v, c.chg, c.rem != 16'd0};
        endcase
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) m <= '0;
        else       m <= model_next(m, i_address, i_write_data, i_mem_write, i_port_in);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            check("cyc port_out", o_port_out, m.port_out);
            check("cyc uart_tx", {31'h0, o_uart_tx}, {31'h0, exp_tx(m)});
            check("cyc sel", {31'h0, o_sel}, {31'h0, i_address[31:4] == BASE[31:4]});
            check("cyc read_data", o_read_data, exp_rd(m, i_address, i_mem_read));
        end
    end

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        @(posedge clk); #1;
        i_address    = a;
        i_write_data = d;
        i_mem_write  = 1'b1;
        @(posedge clk); #1;
        i_mem_write  = 1'b0;
        i_address    = BASE + 32'hC;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d, output logic s);
        i_address = a;
        #1;
        d = o_read_data;
        s = o_sel;
        i_address = BASE + 32'hC;
    endtask

    task automatic rd_chk(input string name, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] d;
        logic        s;
        bus_read(a, d, s);
        check(name, d, exp);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        logic [9:0]  fr55;
        logic [9:0]  fr0f;
        logic [31:0] d;
        logic        s;
        fr55 = 10'b1010101010;
        fr0f = 10'b1000011110;

        step(3);
        reset = 1'b0;
        check("reset port_out", o_port_out, 32'h0);
        check("reset tx", {31'h0, o_uart_tx}, 32'h1);
        rd_chk("reset STATUS", BASE + 32'hC, 32'h0);

        // output port
        bus_write(32'h100, 32'hDEADBEEF);
        check("sw PORT_OUT", o_port_out, 32'hDEADBEEF);
        rd_chk("lw PORT_OUT", 32'h100, 32'hDEADBEEF);
        rd_chk("lw UART_TX", 32'h108, 32'h0);
        bus_read(32'h0FC, d, s);
        check("lw 0x0FC sel", {31'h0, s}, 32'h0);
        check("lw 0x0FC data", d, 32'h0);

        // input port and change flag
        step(1);
        i_port_in = 8'hA5;
        step(2);
        rd_chk("PORT_IN after 2 edges", 32'h104, 32'hA5);
        step(1);
        rd_chk("STATUS chg set", 32'h10C, 32'h2);
        bus_write(32'h10C, 32'h2);
        rd_chk("STATUS chg cleared", 32'h10C, 32'h0);
        step(1);
        i_port_in = 8'h5A;
        step(2);
        i_address    = 32'h10C;
        i_write_data = 32'h2;
        i_mem_write  = 1'b1;
        step(1);
        i_mem_write  = 1'b0;
        i_address    = BASE + 32'hC;
        rd_chk("STATUS set wins over clear", 32'h10C, 32'h2);
        bus_write(32'h10C, 32'h2);
        rd_chk("STATUS cleared again", 32'h10C, 32'h0);

        // single frame 0x55
        bus_write(32'h108, 32'h55);
        for (int i = 0; i < 10; i++) begin
            check($sformatf("frame55 bit%0d", i), {31'h0, o_uart_tx}, {31'h0, fr55[i]});
            rd_chk($sformatf("frame55 busy%0d", i), 32'h10C, 32'h1);
            step(CPB);
        end
        check("frame55 idle tx", {31'h0, o_uart_tx}, 32'h1);
        rd_chk("frame55 idle STATUS", 32'h10C, 32'h0);

        // store while busy
        bus_write(32'h108, 32'h55);
        bus_write(32'h108, 32'h0F);
        rd_chk("busy store STATUS", 32'h10C, HOLD ? 32'h5 : 32'h1);
        step(FRAME - 2);
        if (HOLD) begin
            for (int i = 0; i < 10; i++) begin
                check($sformatf("frame0F bit%0d", i), {31'h0, o_uart_tx}, {31'h0, fr0f[i]});
                rd_chk($sformatf("frame0F busy%0d", i), 32'h10C, 32'h1);
                step(CPB);
            end
        end else begin
            check("dropped store tx idle", {31'h0, o_uart_tx}, 32'h1);
            step(FRAME);
            check("dropped store still idle", {31'h0, o_uart_tx}, 32'h1);
        end
        rd_chk("after busy store STATUS", 32'h10C, 32'h0);

        // writes to read-only / write-only registers
        bus_write(32'h104, 32'hFFFF_FFFF);
        rd_chk("PORT_IN unaffected", 32'h104, 32'h5A);
        bus_write(32'h108, 32'hC3);
        rd_chk("UART_TX reads 0", 32'h108, 32'h0);
        rd_chk("PORT_OUT kept", 32'h100, 32'hDEADBEEF);
        step(20);

        // async reset mid-frame, between edges
        check("pre-reset busy tx low or high frame", {31'h0, o_uart_tx}, {31'h0, exp_tx(m)});
        @(posedge clk); #2;
        reset = 1'b1;
        #1;
        check("async reset port_out", o_port_out, 32'h0);
        check("async reset tx", {31'h0, o_uart_tx}, 32'h1);
        rd_chk("async reset STATUS", 32'h10C, 32'h0);
        reset = 1'b0;
        step(10);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
